// File: rtl/daq_pkg.sv
// Shared DAQ definitions: event geometry and the reader FSM encoding.
// Capture-side and readout-side blocks both import this so event length lives in one place.
package daq_pkg;

    localparam int WORDS_PER_EVENT = 16;
    localparam int DATA_WIDTH      = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } reader_state_t;

endpackage

// File: rtl/axis_out_buffer.sv
// Small synchronous FIFO with push/pop, occupancy and a head output taken straight from storage.
// The head is a mux over registers, so it changes only on a clock edge.
module axis_out_buffer #(
    parameter int  DATA_WIDTH = 64,
    parameter int  DEPTH      = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [OCC_W-1:0]      occ_o,
    output logic                  empty_o,
    output logic                  full_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  push_ok, pop_ok;

    assign empty_o = (occ_q == OCC_W'(0));
    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/event_reader.sv
// Drains whole events from a standard-mode FIFO and streams them out over AXI4-Stream with tlast
// on the final word; reads are throttled so the 4-entry output buffer can never overflow.
module event_reader
    import daq_pkg::*;
#(
    parameter int WORDS_PER_EVENT = daq_pkg::WORDS_PER_EVENT,
    parameter int DATA_WIDTH      = daq_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH     = 15
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   enable_i,
    input  logic                   empty_i,
    input  logic [COUNT_WIDTH-1:0] rd_data_count_i,
    input  logic [DATA_WIDTH-1:0]  dout_i,
    output logic                   rd_en_o,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   event_sent_o,
    output logic [31:0]            events_sent_o
);

    localparam int CNT_W = $clog2(WORDS_PER_EVENT) + 1;
    localparam logic [CNT_W-1:0] N_WORDS  = CNT_W'(WORDS_PER_EVENT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_EVENT - 1);

    reader_state_t    state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             inflight_q, inflight_d;
    logic             event_sent_q, event_sent_d;
    logic [31:0]      events_sent_q, events_sent_d;

    logic [2:0]       occ;
    logic             buf_empty;
    logic             buf_full;
    logic             handshake;
    logic             start;

    axis_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (4)
    ) u_out_buf (
        .clk     (clk),
        .aresetn (aresetn),
        .push_i  (inflight_q),
        .data_i  (dout_i),
        .pop_i   (handshake),
        .head_o  (m_axis_tdata),
        .occ_o   (occ),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    // A read is only issued while the buffer plus the word already in flight leaves room.
    assign rd_en_o = (state_q == STREAM) && (rd_cnt_q < N_WORDS) && !empty_i && !buf_full
                     && (({1'b0, occ} + {3'b000, inflight_q}) < 4'd3);

    assign m_axis_tvalid = !buf_empty;
    assign m_axis_tlast  = (tx_cnt_q == LAST_IDX) && m_axis_tvalid;
    assign handshake     = m_axis_tvalid && m_axis_tready;
    assign start         = enable_i && (rd_data_count_i >= COUNT_WIDTH'(WORDS_PER_EVENT));
    assign event_sent_o  = event_sent_q;
    assign events_sent_o = events_sent_q;

    // FSM next-state, word counters and completion bookkeeping.
    always_comb begin
        state_d       = state_q;
        rd_cnt_d      = rd_cnt_q;
        tx_cnt_d      = tx_cnt_q;
        inflight_d    = rd_en_o;
        event_sent_d  = 1'b0;
        events_sent_d = events_sent_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                    tx_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (rd_en_o) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
                if (handshake) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    if (tx_cnt_q == LAST_IDX) begin
                        state_d       = DONE;
                        event_sent_d  = 1'b1;
                        events_sent_d = events_sent_q + 32'd1;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers; an async reset drops any partial event.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            rd_cnt_q      <= '0;
            tx_cnt_q      <= '0;
            inflight_q    <= 1'b0;
            event_sent_q  <= 1'b0;
            events_sent_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            inflight_q    <= inflight_d;
            event_sent_q  <= event_sent_d;
            events_sent_q <= events_sent_d;
        end
    end

endmodule
